wb_slave_mem_responder: RTL and testbench
=========================================

// Module: wb_slave_mem_responder
// PURPOSE
// Wishbone classic (single-access) slave: on-chip word-addressed RAM answering write/read cycles from a bus master.
// Inserts a parameterised number of wait states, honours byte selects, flags out-of-range addresses with err_o.
// Sits as the responder endpoint in the SoC simulation, opposite the memory-access master, directly or behind the interconnect.
// PARAMETERS
// ADDR_WIDTH   32   width of adr_i (word address)
// DATA_WIDTH   32   width of dat_i/dat_o; multiple of 8
// DEPTH        16   number of words in the RAM
// BASE_ADDR    0    first word address decoded; valid range BASE_ADDR..BASE_ADDR+DEPTH-1
// WAIT_STATES  0    extra cycles between request capture and ack/err (0..15)
// PORTS
// clk_i    in   1               clock; all logic on rising edge
// rst_ni   in   1               reset, asynchronous, active-low
// cyc_i    in   1               bus cycle valid
// stb_i    in   1               strobe; request = cyc_i & stb_i
// we_i     in   1               1 = write, 0 = read
// adr_i    in   ADDR_WIDTH      word address
// dat_i    in   DATA_WIDTH      write data
// sel_i    in   DATA_WIDTH/8    byte-lane enables for writes
// dat_o    out  DATA_WIDTH      read data, registered
// ack_o    out  1               normal termination, one-cycle pulse
// err_o    out  1               error termination (address out of range), one-cycle pulse
// BEHAVIOUR
// - Reset (rst_ni low, async): state=IDLE, ack_o=0, err_o=0, dat_o=0, wait counter=0. RAM contents not reset.
// - FSM states: IDLE, WAIT, RESP.
// - IDLE: at an edge with cyc_i&stb_i=1, capture we_i/adr_i/dat_i/sel_i, load cnt=WAIT_STATES, go WAIT.
// - WAIT: if cyc_i=0, abort: go IDLE, no access, no ack/err.
//   Else if cnt!=0: cnt<=cnt-1. Else terminate: go RESP.
//   - In range, write: write enabled byte lanes, ack_o<=1.
//   - In range, read: dat_o<=mem[idx], ack_o<=1.
//   - Out of range: err_o<=1, no RAM write, dat_o unchanged.
// - RESP: ack_o<=0, err_o<=0, go IDLE unconditionally; stb_i is ignored in RESP.
// - Latency: request sampled at edge t -> ack_o/err_o high during cycle after edge t+1+WAIT_STATES, exactly one cycle.
// - ack_o and err_o never both high. Minimum spacing between terminations: WAIT_STATES+3 cycles.
// - Index: idx = adr_i - BASE_ADDR, computed in ADDR_WIDTH bits.
//   - In range iff adr_i >= BASE_ADDR and idx < DEPTH; no wrap-around aliasing.
//   - RAM index width = $clog2(DEPTH).
// - sel_i=0 on a write: ack_o issued, RAM unchanged. sel_i ignored for reads; full word returned.
// - dat_o holds last read value between reads; writes do not change dat_o.
// - Inputs changing while in WAIT/RESP are ignored (captured copies used), except cyc_i abort in WAIT.
// - Reset asserted mid-WAIT: return to IDLE immediately, no ack/err, no RAM write.
// TESTING
// T1 reset: rst_ni=0 with cyc_i=stb_i=1 -> ack_o=err_o=0, dat_o=0; hold 3 cycles after release with no request -> no ack.
// T2 write/read, WAIT_STATES=2, BASE_ADDR=0:
//   - write 0xDEADBEEF @3, sel=4'hF sampled edge t -> ack_o high only in cycle after edge t+3.
//   - read @3 -> dat_o=0xDEADBEEF with ack_o.
// T3 byte lanes: write 0x11223344 @5 sel=F, then 0xAABBCCDD sel=4'b0101 -> read @5 returns 0x11BB33DD.
// T4 range, BASE_ADDR=8, DEPTH=16:
//   - write @7 or @24 -> err_o one cycle, ack_o=0.
//   - read @8 unaffected; prior dat_o retained after an err.
// T5 abort/reset: cyc_i dropped in WAIT (WAIT_STATES=3) -> no ack, RAM @2 unchanged.
//   Repeat with rst_ni pulsed low in WAIT -> same result.
// T6 master pattern: write-then-read loop, 10 random values/addresses, stb_i dropped the cycle after ack ->
//   every read matches, exactly one ack per strobe, no spurious second access.

Source files
------------

// File: rtl/wb_slave_mem_responder.sv
// Wishbone classic slave backed by a word-addressed on-chip RAM.
// Adds a fixed number of wait states, applies byte-lane writes and answers out-of-range addresses with err_o.
module wb_slave_mem_responder #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH       = 16,
    parameter int BASE_ADDR   = 0,
    parameter int WAIT_STATES = 0
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    cyc_i,
    input  logic                    stb_i,
    input  logic                    we_i,
    input  logic [ADDR_WIDTH-1:0]   adr_i,
    input  logic [DATA_WIDTH-1:0]   dat_i,
    input  logic [DATA_WIDTH/8-1:0] sel_i,
    output logic [DATA_WIDTH-1:0]   dat_o,
    output logic                    ack_o,
    output logic                    err_o
);

    localparam int NB    = DATA_WIDTH / 8;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam logic [ADDR_WIDTH-1:0] BASE_A  = ADDR_WIDTH'(BASE_ADDR);
    localparam logic [ADDR_WIDTH-1:0] DEPTH_A = ADDR_WIDTH'(DEPTH);
    localparam logic [3:0]            WAIT_LD = 4'(WAIT_STATES);

    logic [1:0]            state_r;
    logic [3:0]            cnt_r;
    logic                  we_r;
    logic [ADDR_WIDTH-1:0] adr_r;
    logic [DATA_WIDTH-1:0] dat_r;
    logic [NB-1:0]         sel_r;
    logic [DATA_WIDTH-1:0] mem_r [DEPTH];

    logic [ADDR_WIDTH-1:0] idx_s;
    logic [IDX_W-1:0]      ram_idx_s;
    logic                  in_range_s;
    logic                  term_s;
    logic                  mem_we_s;

    // Address decode on the captured request; the subtraction wraps, so the lower bound is checked separately.
    always_comb begin
        idx_s     = adr_r - BASE_A;
        ram_idx_s = idx_s[IDX_W-1:0];
        if ((adr_r >= BASE_A) && (idx_s < DEPTH_A)) begin
            in_range_s = 1'b1;
        end else begin
            in_range_s = 1'b0;
        end
    end

    // Termination happens only when the wait count is exhausted and the master still holds the cycle.
    always_comb begin
        if ((state_r == ST_WAIT) && cyc_i && (cnt_r == 4'd0)) begin
            term_s = 1'b1;
        end else begin
            term_s = 1'b0;
        end
        mem_we_s = term_s & we_r & in_range_s;
    end

    // Bus handshake FSM, request capture and registered responses.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r <= ST_IDLE;
            cnt_r   <= 4'd0;
            we_r    <= 1'b0;
            adr_r   <= {ADDR_WIDTH{1'b0}};
            dat_r   <= {DATA_WIDTH{1'b0}};
            sel_r   <= {NB{1'b0}};
            dat_o   <= {DATA_WIDTH{1'b0}};
            ack_o   <= 1'b0;
            err_o   <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    ack_o <= 1'b0;
                    err_o <= 1'b0;
                    if (cyc_i && stb_i) begin
                        we_r    <= we_i;
                        adr_r   <= adr_i;
                        dat_r   <= dat_i;
                        sel_r   <= sel_i;
                        cnt_r   <= WAIT_LD;
                        state_r <= ST_WAIT;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_WAIT: begin
                    if (!cyc_i) begin
                        state_r <= ST_IDLE;
                    end else if (cnt_r != 4'd0) begin
                        cnt_r <= cnt_r - 4'd1;
                    end else begin
                        state_r <= ST_RESP;
                        if (in_range_s) begin
                            ack_o <= 1'b1;
                            if (!we_r) begin
                                dat_o <= mem_r[ram_idx_s];
                            end else begin
                                dat_o <= dat_o;
                            end
                        end else begin
                            err_o <= 1'b1;
                        end
                    end
                end
                ST_RESP: begin
                    ack_o   <= 1'b0;
                    err_o   <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    ack_o   <= 1'b0;
                    err_o   <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // RAM byte-lane write port; contents deliberately survive reset.
    always_ff @(posedge clk_i) begin
        if (mem_we_s) begin
            for (int b = 0; b < NB; b++) begin
                if (sel_r[b]) begin
                    mem_r[ram_idx_s][8*b +: 8] <= dat_r[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_wb_slave_mem_responder.sv
// Scoreboard bench for wb_slave_mem_responder: three instances with different wait-state/base settings
// share the data/address lines and have private cyc/stb strobes.
module tb_wb_slave_mem_responder;

    logic        clk_i;
    logic        rst_ni;
    logic [2:0]  cyc_s;
    logic [2:0]  stb_s;
    logic        we_s;
    logic [31:0] adr_s;
    logic [31:0] dat_s;
    logic [3:0]  sel_s;
    logic [31:0] dat_o_s [3];
    logic [2:0]  ack_s;
    logic [2:0]  err_s;

    typedef struct {
        int          inst;
        bit          err;
        logic [31:0] dat;
    } exp_t;

    exp_t        exp_q [$];
    int          n_total;
    int          n_pass;
    int          term_cnt [3];
    int          exp_cnt [3];
    logic [31:0] mem_m [3][16];
    logic [31:0] last_rd [3];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        wb_slave_mem_responder #(
            .ADDR_WIDTH (32),
            .DATA_WIDTH (32),
            .DEPTH      (16),
            .BASE_ADDR  ((g == 1) ? 8 : 0),
            .WAIT_STATES((g == 0) ? 2 : ((g == 1) ? 0 : 3))
        ) u_dut (
            .clk_i (clk_i),
            .rst_ni(rst_ni),
            .cyc_i (cyc_s[g]),
            .stb_i (stb_s[g]),
            .we_i  (we_s),
            .adr_i (adr_s),
            .dat_i (dat_s),
            .sel_i (sel_s),
            .dat_o (dat_o_s[g]),
            .ack_o (ack_s[g]),
            .err_o (err_s[g])
        );
    end

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    function automatic int ws_of(input int g);
        return (g == 0) ? 2 : ((g == 1) ? 0 : 3);
    endfunction

    function automatic int base_of(input int g);
        return (g == 1) ? 8 : 0;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Monitor: every termination pops one expectation and is compared against it.
    always @(negedge clk_i) begin
        for (int g = 0; g < 3; g++) begin
            if (ack_s[g] || err_s[g]) begin
                exp_t e;
                term_cnt[g]++;
                check_eq("ack_err_excl", {31'd0, ack_s[g] & err_s[g]}, 32'd0);
                if (exp_q.size() == 0) begin
                    check_eq("spurious_term", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check_eq("term_inst", g, e.inst);
                    check_eq("err_o", {31'd0, err_s[g]}, {31'd0, e.err});
                    check_eq("ack_o", {31'd0, ack_s[g]}, {31'd0, ~e.err});
                    check_eq("dat_o", dat_o_s[g], e.dat);
                end
            end
        end
    end

    // One full classic cycle on instance g; the model predicts the response and dat_o afterwards.
    task automatic xfer(input int g, input bit we, input logic [31:0] adr,
                        input logic [31:0] dat, input logic [3:0] sel);
        exp_t e;
        int   n;
        int   idx;
        bit   ok;
        idx = int'(adr) - base_of(g);
        ok  = (idx >= 0) && (idx < 16);
        if (ok && we) begin
            for (int b = 0; b < 4; b++) begin
                if (sel[b]) mem_m[g][idx][8*b +: 8] = dat[8*b +: 8];
            end
        end else if (ok) begin
            last_rd[g] = mem_m[g][idx];
        end
        e.inst = g;
        e.err  = !ok;
        e.dat  = last_rd[g];
        exp_q.push_back(e);
        exp_cnt[g]++;

        @(negedge clk_i);
        we_s     = we;
        adr_s    = adr;
        dat_s    = dat;
        sel_s    = sel;
        cyc_s[g] = 1'b1;
        stb_s[g] = 1'b1;
        n = 0;
        do begin
            @(posedge clk_i);
            #1;
            n++;
        end while (!(ack_s[g] || err_s[g]) && n < 40);
        check_eq("latency", n, ws_of(g) + 2);
        if (n >= 40 && exp_q.size() != 0) void'(exp_q.pop_back());
        @(negedge clk_i);
        cyc_s[g] = 1'b0;
        stb_s[g] = 1'b0;
        we_s     = 1'b0;
        adr_s    = 32'hFFFF_0000;
        dat_s    = 32'h5A5A_5A5A;
        @(posedge clk_i);
        #1;
        check_eq("one_cycle_pulse", {30'd0, ack_s[g], err_s[g]}, 32'd0);
    endtask

    // Start a write on instance 2, then kill it in WAIT by dropping cyc or by reset.
    task automatic aborted_write(input bit use_reset);
        @(negedge clk_i);
        we_s     = 1'b1;
        adr_s    = 32'd2;
        dat_s    = 32'hFFFF_FFFF;
        sel_s    = 4'hF;
        cyc_s[2] = 1'b1;
        stb_s[2] = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        cyc_s[2] = 1'b0;
        stb_s[2] = 1'b0;
        if (use_reset) begin
            rst_ni = 1'b0;
            #1;
            check_eq("rst_in_wait", {30'd0, ack_s[2], err_s[2]}, 32'd0);
            @(negedge clk_i);
            rst_ni = 1'b1;
            for (int g = 0; g < 3; g++) last_rd[g] = 32'd0;
        end else begin
            @(negedge clk_i);
        end
        repeat (8) @(posedge clk_i);
        #1;
        check_eq("abort_no_term", term_cnt[2], exp_cnt[2]);
    endtask

    initial begin
        n_total = 0;
        n_pass  = 0;
        for (int g = 0; g < 3; g++) begin
            term_cnt[g] = 0;
            exp_cnt[g]  = 0;
            last_rd[g]  = 32'd0;
        end
        rst_ni = 1'b0;
        cyc_s  = 3'b111;
        stb_s  = 3'b111;
        we_s   = 1'b0;
        adr_s  = 32'd0;
        dat_s  = 32'd0;
        sel_s  = 4'hF;

        // T1: reset holds everything quiet even with a request pending.
        repeat (3) @(posedge clk_i);
        #1;
        for (int g = 0; g < 3; g++) begin
            check_eq("rst_ack_err", {30'd0, ack_s[g], err_s[g]}, 32'd0);
            check_eq("rst_dat", dat_o_s[g], 32'd0);
        end
        @(negedge clk_i);
        cyc_s  = 3'b000;
        stb_s  = 3'b000;
        rst_ni = 1'b1;
        repeat (3) @(posedge clk_i);
        #1;
        check_eq("idle_no_ack", {29'd0, ack_s | err_s}, 32'd0);

        // T2: write then read with two wait states.
        xfer(0, 1'b1, 32'd3, 32'hDEAD_BEEF, 4'hF);
        check_eq("t2_write_keeps_dat", dat_o_s[0], 32'd0);
        xfer(0, 1'b0, 32'd3, 32'd0, 4'h0);
        check_eq("t2_read", dat_o_s[0], 32'hDEAD_BEEF);

        // T3: partial byte-lane write, plus sel=0 write leaving RAM untouched.
        xfer(0, 1'b1, 32'd5, 32'h1122_3344, 4'hF);
        xfer(0, 1'b1, 32'd5, 32'hAABB_CCDD, 4'b0101);
        xfer(0, 1'b1, 32'd5, 32'h9999_9999, 4'h0);
        xfer(0, 1'b0, 32'd5, 32'd0, 4'h0);
        check_eq("t3_lanes", dat_o_s[0], 32'h11BB_33DD);

        // T4: BASE_ADDR=8 range edges, no wait states.
        xfer(1, 1'b1, 32'd8, 32'hCAFE_0008, 4'hF);
        xfer(1, 1'b1, 32'd23, 32'hCAFE_0023, 4'hF);
        xfer(1, 1'b0, 32'd8, 32'd0, 4'h0);
        xfer(1, 1'b1, 32'd7, 32'hBAD0_0007, 4'hF);
        check_eq("t4_err_keeps_dat", dat_o_s[1], 32'hCAFE_0008);
        xfer(1, 1'b1, 32'd24, 32'hBAD0_0024, 4'hF);
        xfer(1, 1'b0, 32'd24, 32'd0, 4'h0);
        xfer(1, 1'b0, 32'hFFFF_FFF8, 32'd0, 4'h0);
        xfer(1, 1'b0, 32'd8, 32'd0, 4'h0);
        check_eq("t4_read8", dat_o_s[1], 32'hCAFE_0008);
        xfer(1, 1'b0, 32'd23, 32'd0, 4'h0);
        check_eq("t4_read23", dat_o_s[1], 32'hCAFE_0023);

        // T5: abort by cyc drop and by reset; RAM word 2 must survive both.
        xfer(2, 1'b1, 32'd2, 32'h1234_5678, 4'hF);
        aborted_write(1'b0);
        xfer(2, 1'b0, 32'd2, 32'd0, 4'h0);
        check_eq("t5_cyc_abort", dat_o_s[2], 32'h1234_5678);
        aborted_write(1'b1);
        xfer(2, 1'b0, 32'd2, 32'd0, 4'h0);
        check_eq("t5_rst_abort", dat_o_s[2], 32'h1234_5678);

        // T6: master-style write-then-read loop on random addresses/data.
        for (int i = 0; i < 10; i++) begin
            logic [31:0] a;
            logic [31:0] v;
            a = 32'($urandom_range(0, 15));
            v = $urandom;
            xfer(0, 1'b1, a, v, 4'hF);
            xfer(0, 1'b0, a, 32'd0, 4'h0);
            check_eq("t6_read", dat_o_s[0], v);
        end

        repeat (4) @(posedge clk_i);
        #1;
        for (int g = 0; g < 3; g++) begin
            check_eq("term_count", term_cnt[g], exp_cnt[g]);
        end
        check_eq("queue_drained", exp_q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

endmodule
